// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the register-file writeback
//               scheduler: register geometry, the hard-wired zero register
//               and the writeback source encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LD   = 2'd2
  } wb_src_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_scheduler_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits for pending writes. Register 0 is
//               never busy.
// Ports       : clk, rst_n          - clock, async active-low reset
//               i_set_en/i_set_addr - mark a register busy (issue)
//               i_clr_en/i_clr_addr - mark a register free (write commit)
//               i_rd_addr0/1        - decode source lookups -> o_rd_busy0/1
//               i_issue_addr        - destination lookup    -> o_issue_busy
//               i_wb_addr           - writeback lookup      -> o_wb_busy
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr0,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_issue_addr,
  input  logic [ADDR_W-1:0] i_wb_addr,
  output logic              o_rd_busy0,
  output logic              o_rd_busy1,
  output logic              o_issue_busy,
  output logic              o_wb_busy
);

  logic [NUM_REGS-1:0] w_busy;

  // Register 0 is hard-wired to zero, so it can never have a pending write.
  assign w_busy[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_busy_bit
    logic r_bit;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_bit <= 1'b0;
      end else if (i_set_en && (i_set_addr == ADDR_W'(i))) begin
        r_bit <= 1'b1;
      end else if (i_clr_en && (i_clr_addr == ADDR_W'(i))) begin
        r_bit <= 1'b0;
      end
    end
    assign w_busy[i] = r_bit;
  end

  assign o_rd_busy0   = w_busy[i_rd_addr0];
  assign o_rd_busy1   = w_busy[i_rd_addr1];
  assign o_issue_busy = w_busy[i_issue_addr];
  assign o_wb_busy    = w_busy[i_wb_addr];

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Owns the register-file write port. Arbitrates ALU and load
//               writebacks (ALU priority with load anti-starvation), registers
//               the winner onto the port and tracks pending writes so decode
//               can stall on RAW/WAW hazards.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               issue_valid_i/addr_i/ready_o   - destination reservation
//               rd_addr0/1_i, rd_busy0/1_o     - source hazard lookups
//               alu_valid/addr/data_i, ready_o - ALU writeback request
//               ld_valid/addr/data_i, ready_o  - load writeback request
//               rf_we_o/rf_wr_addr_o/data_o    - register file write port
//               wb_err_o                       - sticky write-to-idle error
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int DATA_W     = regfile_pkg::REG_DATA_W,
  parameter int ADDR_W     = regfile_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = regfile_pkg::NUM_REGS,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  output logic              issue_ready_o,
  input  logic [ADDR_W-1:0] rd_addr0_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  output logic              rd_busy0_o,
  output logic              rd_busy1_o,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_wr_addr_o,
  output logic [DATA_W-1:0] rf_wr_data_o,
  output logic              wb_err_o
);

  import regfile_pkg::*;

  localparam int                    c_STREAK_W   = $clog2(STARVE_MAX + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0]     c_ZERO_ADDR  = ADDR_W'(REG_ZERO);

  wb_src_t           w_src;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_fire;
  logic              w_nonzero;
  logic              w_issue_busy;
  logic              w_wb_busy;
  logic              w_set_en;

  logic [c_STREAK_W-1:0] r_streak;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  r_err;

  // ALU wins unless the load has already watched STARVE_MAX ALU grants.
  always_comb begin
    w_src  = WB_NONE;
    w_addr = '0;
    w_data = '0;
    if (alu_valid_i && (!ld_valid_i || (r_streak != c_STREAK_MAX))) begin
      w_src  = WB_ALU;
      w_addr = alu_addr_i;
      w_data = alu_data_i;
    end else if (ld_valid_i) begin
      w_src  = WB_LD;
      w_addr = ld_addr_i;
      w_data = ld_data_i;
    end
  end

  assign alu_ready_o = (w_src == WB_ALU);
  assign ld_ready_o  = (w_src == WB_LD);
  assign w_fire      = (w_src != WB_NONE);
  assign w_nonzero   = (w_addr != c_ZERO_ADDR);

  // Streak only counts ALU wins that happened while a load was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (!ld_valid_i || (w_src == WB_LD)) begin
      r_streak <= '0;
    end else if ((w_src == WB_ALU) && (r_streak != c_STREAK_MAX)) begin
      r_streak <= r_streak + c_STREAK_W'(1);
    end
  end

  // Write stage: address/data follow every handshake, but the enable is
  // suppressed for register 0 so the slot is consumed without a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_fire) begin
      r_we   <= w_nonzero;
      r_addr <= w_addr;
      r_data <= w_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_fire && w_nonzero && !w_wb_busy) begin
      r_err <= 1'b1;
    end
  end

  assign w_set_en = issue_valid_i && !w_issue_busy && (issue_addr_i != c_ZERO_ADDR);

  // Busy is released by the registered write itself, so it drops on the
  // same edge that the register file captures the data.
  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set_en     (w_set_en),
    .i_set_addr   (issue_addr_i),
    .i_clr_en     (r_we),
    .i_clr_addr   (r_addr),
    .i_rd_addr0   (rd_addr0_i),
    .i_rd_addr1   (rd_addr1_i),
    .i_issue_addr (issue_addr_i),
    .i_wb_addr    (w_addr),
    .o_rd_busy0   (rd_busy0_o),
    .o_rd_busy1   (rd_busy1_o),
    .o_issue_busy (w_issue_busy),
    .o_wb_busy    (w_wb_busy)
  );

  assign issue_ready_o = !w_issue_busy;
  assign rf_we_o       = r_we;
  assign rf_wr_addr_o  = r_addr;
  assign rf_wr_data_o  = r_data;
  assign wb_err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Directed self-checking bench for regfile_wb_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst_n;
  logic        issue_valid_i;
  logic [4:0]  issue_addr_i;
  logic        issue_ready_o;
  logic [4:0]  rd_addr0_i;
  logic [4:0]  rd_addr1_i;
  logic        rd_busy0_o;
  logic        rd_busy1_o;
  logic        alu_valid_i;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        alu_ready_o;
  logic        ld_valid_i;
  logic [4:0]  ld_addr_i;
  logic [31:0] ld_data_i;
  logic        ld_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_wr_addr_o;
  logic [31:0] rf_wr_data_o;
  logic        wb_err_o;

  int total = 0;
  int bad   = 0;

  regfile_wb_scheduler #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .NUM_REGS   (32),
    .STARVE_MAX (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid_i),
    .issue_addr_i  (issue_addr_i),
    .issue_ready_o (issue_ready_o),
    .rd_addr0_i    (rd_addr0_i),
    .rd_addr1_i    (rd_addr1_i),
    .rd_busy0_o    (rd_busy0_o),
    .rd_busy1_o    (rd_busy1_o),
    .alu_valid_i   (alu_valid_i),
    .alu_addr_i    (alu_addr_i),
    .alu_data_i    (alu_data_i),
    .alu_ready_o   (alu_ready_o),
    .ld_valid_i    (ld_valid_i),
    .ld_addr_i     (ld_addr_i),
    .ld_data_i     (ld_data_i),
    .ld_ready_o    (ld_ready_o),
    .rf_we_o       (rf_we_o),
    .rf_wr_addr_o  (rf_wr_addr_o),
    .rf_wr_data_o  (rf_wr_data_o),
    .wb_err_o      (wb_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid_i = 1'b0; issue_addr_i = '0;
    rd_addr0_i = '0; rd_addr1_i = '0;
    alu_valid_i = 1'b0; alu_addr_i = '0; alu_data_i = '0;
    ld_valid_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
    step(); step();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", rf_we_o); end
    total++; if (rf_wr_addr_o !== 5'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", rf_wr_addr_o); end
    total++; if (rf_wr_data_o !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", rf_wr_data_o); end
    total++; if (wb_err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", wb_err_o); end
    rd_addr0_i = 5'd5; issue_addr_i = 5'd5; #1;
    total++; if (rd_busy0_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", rd_busy0_o); end
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_issue_wb();
    issue_valid_i = 1'b1; issue_addr_i = 5'd5; rd_addr0_i = 5'd5; #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL t1_issue_ready: got %b want 1", issue_ready_o); end
    step();
    issue_valid_i = 1'b0; #1;
    total++; if (rd_busy0_o !== 1'b1) begin bad++; $display("FAIL t1_busy_set: got %b want 1", rd_busy0_o); end
    alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 32'hDEADBEEF; #1;
    total++; if (alu_ready_o !== 1'b1) begin bad++; $display("FAIL t1_alu_ready: got %b want 1", alu_ready_o); end
    total++; if (ld_ready_o !== 1'b0) begin bad++; $display("FAIL t1_ld_ready: got %b want 0", ld_ready_o); end
    step();
    alu_valid_i = 1'b0;
    total++; if (rf_we_o !== 1'b1) begin bad++; $display("FAIL t1_we: got %b want 1", rf_we_o); end
    total++; if (rf_wr_addr_o !== 5'd5) begin bad++; $display("FAIL t1_addr: got %0d want 5", rf_wr_addr_o); end
    total++; if (rf_wr_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_data: got %h want deadbeef", rf_wr_data_o); end
    total++; if (rd_busy0_o !== 1'b1) begin bad++; $display("FAIL t1_busy_during_we: got %b want 1", rd_busy0_o); end
    step();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL t1_we_drop: got %b want 0", rf_we_o); end
    total++; if (rd_busy0_o !== 1'b0) begin bad++; $display("FAIL t1_busy_clear: got %b want 0", rd_busy0_o); end
    total++; if (wb_err_o !== 1'b0) begin bad++; $display("FAIL t1_err: got %b want 0", wb_err_o); end
  endtask

  task automatic test_back_to_back();
    issue_valid_i = 1'b1; issue_addr_i = 5'd3; step();
    issue_addr_i = 5'd4; step();
    issue_valid_i = 1'b0;
    rd_addr0_i = 5'd3; rd_addr1_i = 5'd4; #1;
    total++; if ({rd_busy0_o, rd_busy1_o} !== 2'b11) begin bad++; $display("FAIL t2_busy34: got %b want 11", {rd_busy0_o, rd_busy1_o}); end
    alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 32'h11;
    ld_valid_i = 1'b1; ld_addr_i = 5'd4; ld_data_i = 32'h22; #1;
    total++; if ({alu_ready_o, ld_ready_o} !== 2'b10) begin bad++; $display("FAIL t2_grant_alu: got %b want 10", {alu_ready_o, ld_ready_o}); end
    step();
    alu_valid_i = 1'b0; #1;
    total++; if ({alu_ready_o, ld_ready_o} !== 2'b01) begin bad++; $display("FAIL t2_grant_ld: got %b want 01", {alu_ready_o, ld_ready_o}); end
    total++; if ({rf_we_o, rf_wr_addr_o, rf_wr_data_o} !== {1'b1, 5'd3, 32'h11}) begin bad++; $display("FAIL t2_wr0: got %b/%0d/%h want 1/3/11", rf_we_o, rf_wr_addr_o, rf_wr_data_o); end
    step();
    ld_valid_i = 1'b0;
    total++; if ({rf_we_o, rf_wr_addr_o, rf_wr_data_o} !== {1'b1, 5'd4, 32'h22}) begin bad++; $display("FAIL t2_wr1: got %b/%0d/%h want 1/4/22", rf_we_o, rf_wr_addr_o, rf_wr_data_o); end
    step();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL t2_we_drop: got %b want 0", rf_we_o); end
    total++; if ({rd_busy0_o, rd_busy1_o} !== 2'b00) begin bad++; $display("FAIL t2_busy_clear: got %b want 00", {rd_busy0_o, rd_busy1_o}); end
    total++; if (wb_err_o !== 1'b0) begin bad++; $display("FAIL t2_err: got %b want 0", wb_err_o); end
  endtask

  task automatic test_starvation();
    logic exp_ld;
    alu_valid_i = 1'b1; alu_addr_i = 5'd0; alu_data_i = 32'h0;
    ld_valid_i = 1'b1; ld_addr_i = 5'd0; ld_data_i = 32'h0;
    for (int i = 0; i < 8; i++) begin
      exp_ld = ((i % 4) == 3);
      #1;
      total++;
      if ({alu_ready_o, ld_ready_o} !== {!exp_ld, exp_ld}) begin
        bad++; $display("FAIL t3_grant[%0d]: got %b want %b", i, {alu_ready_o, ld_ready_o}, {!exp_ld, exp_ld});
      end
      step();
    end
    alu_valid_i = 1'b0; ld_valid_i = 1'b0;
    step();
  endtask

  task automatic test_waw_stall();
    issue_valid_i = 1'b1; issue_addr_i = 5'd7; #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL t4_first_issue: got %b want 1", issue_ready_o); end
    step();
    for (int i = 0; i < 2; i++) begin
      total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL t4_stall[%0d]: got %b want 0", i, issue_ready_o); end
      step();
    end
    alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 32'h77;
    step();
    alu_valid_i = 1'b0;
    total++; if (rf_we_o !== 1'b1) begin bad++; $display("FAIL t4_we: got %b want 1", rf_we_o); end
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL t4_stall_we: got %b want 0", issue_ready_o); end
    step();
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL t4_release: got %b want 1", issue_ready_o); end
    issue_valid_i = 1'b0;
    total++; if (wb_err_o !== 1'b0) begin bad++; $display("FAIL t4_err: got %b want 0", wb_err_o); end
  endtask

  task automatic test_zero_reg();
    alu_valid_i = 1'b1; alu_addr_i = 5'd0; alu_data_i = 32'hFFFFFFFF; #1;
    total++; if (alu_ready_o !== 1'b1) begin bad++; $display("FAIL t5_alu_ready: got %b want 1", alu_ready_o); end
    step();
    alu_valid_i = 1'b0;
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL t5_no_we: got %b want 0", rf_we_o); end
    total++; if (wb_err_o !== 1'b0) begin bad++; $display("FAIL t5_err: got %b want 0", wb_err_o); end
    issue_valid_i = 1'b1; issue_addr_i = 5'd0; step();
    issue_valid_i = 1'b0; rd_addr0_i = 5'd0; #1;
    total++; if (rd_busy0_o !== 1'b0) begin bad++; $display("FAIL t5_busy0: got %b want 0", rd_busy0_o); end
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL t5_issue0_ready: got %b want 1", issue_ready_o); end
  endtask

  task automatic test_err_and_reset();
    ld_valid_i = 1'b1; ld_addr_i = 5'd9; ld_data_i = 32'h99; #1;
    total++; if (ld_ready_o !== 1'b1) begin bad++; $display("FAIL t6_ld_ready: got %b want 1", ld_ready_o); end
    step();
    ld_valid_i = 1'b0;
    total++; if (wb_err_o !== 1'b1) begin bad++; $display("FAIL t6_err_set: got %b want 1", wb_err_o); end
    total++; if ({rf_we_o, rf_wr_addr_o, rf_wr_data_o} !== {1'b1, 5'd9, 32'h99}) begin bad++; $display("FAIL t6_wr: got %b/%0d/%h want 1/9/99", rf_we_o, rf_wr_addr_o, rf_wr_data_o); end
    step();
    total++; if (wb_err_o !== 1'b1) begin bad++; $display("FAIL t6_err_sticky: got %b want 1", wb_err_o); end
    issue_valid_i = 1'b1; issue_addr_i = 5'd12; step();
    issue_addr_i = 5'd13; step();
    issue_valid_i = 1'b0;
    rd_addr1_i = 5'd13;
    alu_valid_i = 1'b1; alu_addr_i = 5'd12; alu_data_i = 32'hC0FFEE;
    step();
    alu_valid_i = 1'b0; #1;
    total++; if (rf_we_o !== 1'b1) begin bad++; $display("FAIL t6_we_before_rst: got %b want 1", rf_we_o); end
    total++; if (rd_busy1_o !== 1'b1) begin bad++; $display("FAIL t6_busy13: got %b want 1", rd_busy1_o); end
    rst_n = 1'b0; #1;
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL t6_rst_we: got %b want 0", rf_we_o); end
    total++; if (wb_err_o !== 1'b0) begin bad++; $display("FAIL t6_rst_err: got %b want 0", wb_err_o); end
    total++; if (rd_busy1_o !== 1'b0) begin bad++; $display("FAIL t6_rst_busy: got %b want 0", rd_busy1_o); end
    step();
    rst_n = 1'b1;
    step();
    total++; if ({rf_we_o, wb_err_o} !== 2'b00) begin bad++; $display("FAIL t6_after_rst: got %b want 00", {rf_we_o, wb_err_o}); end
  endtask

  initial begin
    test_reset();
    test_issue_wb();
    test_back_to_back();
    test_starvation();
    test_waw_stall();
    test_zero_reg();
    test_err_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
